// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the RV32I pipeline stages:
//   XLEN          - datapath / address width
//   RESET_PC      - default first fetch address after reset
//   NOP_INSTR     - bubble encoding (addi x0,x0,0)
//   fetch_state_t - instruction-fetch request FSM states
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // ISSUE : request presented to instruction memory
    // WAIT  : request accepted, response pending
    // HOLD  : response captured in the hold buffer during a stall
    // DRAIN : accepted request whose response must be thrown away
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_chk.sv
// -----------------------------------------------------------------------------
// fetch_stage_chk
// Protocol checker for the fetch stage: instruction memory must never return
// a response while the fetch FSM has nothing outstanding (ISSUE or HOLD).
// Such a response is ignored by the datapath; this only reports it.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   state            - current fetch FSM state
//   imem_resp_valid  - instruction-memory response strobe
// -----------------------------------------------------------------------------
module fetch_stage_chk
    import pipeline_pkg::*;
(
    input logic         clk,
    input logic         rst,
    input fetch_state_t state,
    input logic         imem_resp_valid
);

    // Unsolicited response while nothing is outstanding
    a_no_stray_resp: assert property (
        @(posedge clk) disable iff (rst)
        !(imem_resp_valid && ((state == ISSUE) || (state == HOLD)))
    );

endmodule

// File: rtl/ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register with load, flush-to-bubble and hold controls.
// Priority: rst > flush > load > hold. A flush replaces the instruction with
// the bubble encoding and clears valid; the PC fields are left untouched so
// a bubble still carries the PC of the last real instruction.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   load                - capture load_pc/load_pc4/load_instr, valid=1
//   flush               - insert a bubble (NOP_INSTR, valid=0)
//   load_pc, load_pc4   - PC and PC+4 of the incoming instruction
//   load_instr          - incoming instruction word
//   pc, pc4, instr      - registered IF/ID fields
//   valid               - 0 = bubble
// -----------------------------------------------------------------------------
module ifid_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_pc4,
    input  logic [31:0]     load_instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [31:0]     instr,
    output logic            valid
);

    localparam logic [XLEN-1:0] PC_ZERO  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] PC4_INIT = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc4_r;
    logic [31:0]     instr_r;
    logic            valid_r;

    // Stage register update: reset, bubble insert, load or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= PC_ZERO;
            pc4_r   <= PC4_INIT;
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
        end else if (flush) begin
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
        end else if (load) begin
            pc_r    <= load_pc;
            pc4_r   <= load_pc4;
            instr_r <= load_instr;
            valid_r <= 1'b1;
        end else begin
            pc_r    <= pc_r;
            pc4_r   <= pc4_r;
            instr_r <= instr_r;
            valid_r <= valid_r;
        end
    end

    assign pc    = pc_r;
    assign pc4   = pc4_r;
    assign instr = instr_r;
    assign valid = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage RV32I pipeline: PC register,
// single-outstanding instruction-memory request FSM, one-entry response hold
// buffer and the IF/ID pipeline register.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   pcwrite, fdwrite                - load-use stall controls (0 = hold)
//   branch_taken, branch_target     - EX-stage redirect (target[1:0] ignored)
//   imem_req_valid/addr/ready       - fetch request handshake
//   imem_resp_valid/data            - one-cycle instruction response
//   ifid_pc, ifid_pc4, ifid_instr   - IF/ID fields for decode
//   ifid_valid                      - 0 = bubble
//   fetch_stall                     - decode advanced but received a bubble
// -----------------------------------------------------------------------------
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              XLEN      = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = pipeline_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcwrite,
    input  logic            fdwrite,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,
    output logic            fetch_stall
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    fetch_state_t    state_r;
    fetch_state_t    state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [31:0]     hold_data_r;
    logic [31:0]     hold_data_nxt_s;
    logic            req_valid_r;
    logic            fetch_stall_r;
    logic            fetch_stall_nxt_s;

    logic            advance_s;
    logic            accept_s;
    logic            deliver_valid_s;
    logic [31:0]     deliver_instr_s;
    logic            ifid_load_s;
    logic            ifid_flush_s;
    logic            unused_tgt_lsb_s;

    // Either stall control low freezes the front end
    assign advance_s  = pcwrite & fdwrite;
    // The request is suppressed for as long as reset is held
    assign imem_req_valid = req_valid_r & ~rst;
    assign imem_req_addr  = pc_r;
    assign accept_s   = imem_req_valid & imem_req_ready;
    assign pc_plus4_s = pc_r + PC_STEP;
    assign fetch_stall = fetch_stall_r;
    assign unused_tgt_lsb_s = ^branch_target[1:0];

    // Instruction available for IF/ID this cycle: the live response in WAIT,
    // or the buffered word in HOLD. pc_r has not moved yet in either case.
    always_comb begin
        deliver_valid_s = 1'b0;
        deliver_instr_s = imem_resp_data;
        case (state_r)
            WAIT: begin
                deliver_valid_s = imem_resp_valid;
                deliver_instr_s = imem_resp_data;
            end
            HOLD: begin
                deliver_valid_s = 1'b1;
                deliver_instr_s = hold_data_r;
            end
            default: begin
                deliver_valid_s = 1'b0;
                deliver_instr_s = imem_resp_data;
            end
        endcase
    end

    // Next-state, PC, hold buffer and IF/ID control decisions
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        hold_data_nxt_s   = hold_data_r;
        ifid_load_s       = 1'b0;
        ifid_flush_s      = 1'b0;
        fetch_stall_nxt_s = 1'b0;
        if (rst) begin
            // An accepted but unanswered request still owes a response,
            // which must be swallowed after reset.
            case (state_r)
                WAIT:    state_nxt_s = imem_resp_valid ? ISSUE : DRAIN;
                DRAIN:   state_nxt_s = imem_resp_valid ? ISSUE : DRAIN;
                default: state_nxt_s = ISSUE;
            endcase
        end else if (branch_taken) begin
            pc_nxt_s        = {branch_target[XLEN-1:2], 2'b00};
            hold_data_nxt_s = NOP_INSTR;
            ifid_flush_s    = 1'b1;
            case (state_r)
                ISSUE:   state_nxt_s = accept_s ? DRAIN : ISSUE;
                WAIT:    state_nxt_s = imem_resp_valid ? ISSUE : DRAIN;
                HOLD:    state_nxt_s = ISSUE;
                DRAIN:   state_nxt_s = imem_resp_valid ? ISSUE : DRAIN;
                default: state_nxt_s = ISSUE;
            endcase
        end else begin
            case (state_r)
                ISSUE: begin
                    state_nxt_s = accept_s ? WAIT : ISSUE;
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (advance_s) begin
                            state_nxt_s = ISSUE;
                        end else begin
                            state_nxt_s     = HOLD;
                            hold_data_nxt_s = imem_resp_data;
                        end
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end
                HOLD: begin
                    if (advance_s) begin
                        state_nxt_s     = ISSUE;
                        hold_data_nxt_s = NOP_INSTR;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                DRAIN: begin
                    state_nxt_s = imem_resp_valid ? ISSUE : DRAIN;
                end
                default: begin
                    state_nxt_s = ISSUE;
                end
            endcase

            if (advance_s) begin
                if (deliver_valid_s) begin
                    ifid_load_s = 1'b1;
                    pc_nxt_s    = pc_plus4_s;
                end else begin
                    ifid_flush_s      = 1'b1;
                    fetch_stall_nxt_s = 1'b1;
                end
            end else begin
                ifid_load_s  = 1'b0;
                ifid_flush_s = 1'b0;
            end
        end
    end

    // Fetch state, PC, hold buffer and registered request/stall flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            hold_data_r   <= NOP_INSTR;
            fetch_stall_r <= 1'b0;
        end else begin
            pc_r          <= pc_nxt_s;
            hold_data_r   <= hold_data_nxt_s;
            fetch_stall_r <= fetch_stall_nxt_s;
        end
        state_r     <= state_nxt_s;
        req_valid_r <= (state_nxt_s == ISSUE);
    end

    ifid_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load_s),
        .flush      (ifid_flush_s),
        .load_pc    (pc_r),
        .load_pc4   (pc_plus4_s),
        .load_instr (deliver_instr_s),
        .pc         (ifid_pc),
        .pc4        (ifid_pc4),
        .instr      (ifid_instr),
        .valid      (ifid_valid)
    );

    fetch_stage_chk u_chk (
        .clk             (clk),
        .rst             (rst),
        .state           (state_r),
        .imem_resp_valid (imem_resp_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A transaction-level model (program counter,
// one in-flight request flagged live/dead, one buffered word) predicts every
// output each cycle; hand-computed literals pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pcwrite;
    logic        fdwrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_stall;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;
    int mem_lat = 1;
    logic [31:0] acc_q[$];

    typedef struct packed {
        logic [31:0] pc;
        logic        busy;
        logic        dead;
        logic        buf_full;
        logic [31:0] bufd;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] ifinstr;
        logic        ifvalid;
        logic        stall;
    } model_t;

    model_t m;

    fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pcwrite         (pcwrite),
        .fdwrite         (fdwrite),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .ifid_pc         (ifid_pc),
        .ifid_pc4        (ifid_pc4),
        .ifid_instr      (ifid_instr),
        .ifid_valid      (ifid_valid),
        .fetch_stall     (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural fetch model: one clock edge of the fetch rules
    function automatic model_t model_step(input model_t s, input logic r, input logic br,
                                          input logic [31:0] tgt, input logic adv,
                                          input logic rdy, input logic rv,
                                          input logic [31:0] rd);
        model_t n;
        logic acc;
        logic have;
        logic [31:0] word;
        n    = s;
        acc  = !r && !s.busy && !s.buf_full && rdy;
        have = 1'b0;
        word = 32'h0000_0000;
        if (r) begin
            n.busy = s.busy && !rv;
            n.dead = 1'b1;
            n.buf_full = 1'b0;
            n.pc = 32'h0000_0000;
            n.ifpc = 32'h0000_0000;
            n.ifpc4 = 32'h0000_0004;
            n.ifinstr = NOP;
            n.ifvalid = 1'b0;
            n.stall = 1'b0;
        end else if (br) begin
            n.busy = (s.busy && !rv) || acc;
            n.dead = 1'b1;
            n.buf_full = 1'b0;
            n.pc = tgt & 32'hFFFF_FFFC;
            n.ifinstr = NOP;
            n.ifvalid = 1'b0;
            n.stall = 1'b0;
        end else begin
            if (s.buf_full) begin
                have = 1'b1;
                word = s.bufd;
            end else if (s.busy && rv && !s.dead) begin
                have = 1'b1;
                word = rd;
            end
            if (s.busy && rv) n.busy = 1'b0;
            if (adv) begin
                if (have) begin
                    n.ifpc = s.pc;
                    n.ifpc4 = s.pc + 32'd4;
                    n.ifinstr = word;
                    n.ifvalid = 1'b1;
                    n.pc = s.pc + 32'd4;
                    n.buf_full = 1'b0;
                    n.stall = 1'b0;
                end else begin
                    n.ifinstr = NOP;
                    n.ifvalid = 1'b0;
                    n.stall = 1'b1;
                end
            end else begin
                n.stall = 1'b0;
                if (have && !s.buf_full) begin
                    n.buf_full = 1'b1;
                    n.bufd = word;
                end
            end
            if (acc) begin
                n.busy = 1'b1;
                n.dead = 1'b0;
            end
        end
        return n;
    endfunction

    // Model advances on every rising edge from the same inputs as the DUT
    initial begin
        m = '0;
        forever begin
            @(posedge clk);
            m = model_step(m, rst, branch_taken, branch_target, pcwrite & fdwrite,
                           imem_req_ready, imem_resp_valid, imem_resp_data);
        end
    end

    // Instruction memory: answers each accepted request mem_lat cycles later
    initial begin
        int pend;
        logic [31:0] pdata;
        pend = 0;
        pdata = 32'h0000_0000;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0000_0000;
        forever begin
            @(posedge clk);
            if (imem_req_valid && imem_req_ready) begin
                acc_q.push_back(imem_req_addr);
                pend = mem_lat;
                pdata = instr_of(imem_req_addr);
            end
            #1;
            imem_resp_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data = pdata;
                end
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check32("req_valid", imem_req_valid, !rst && !m.busy && !m.buf_full);
                if (!rst && !m.busy && !m.buf_full) check32("req_addr", imem_req_addr, m.pc);
                check32("ifid_pc", ifid_pc, m.ifpc);
                check32("ifid_pc4", ifid_pc4, m.ifpc4);
                check32("ifid_instr", ifid_instr, m.ifinstr);
                check32("ifid_valid", ifid_valid, m.ifvalid);
                check32("fetch_stall", fetch_stall, m.stall);
            end
        end
    end

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!imem_req_valid && n < 50) begin
            step(1);
            n++;
        end
        checks++;
        if (imem_req_valid) passes++;
        else $display("FAIL %s: no request within 50 cycles", name);
    endtask

    task automatic wait_accept(input string name, input logic [31:0] addr);
        int n;
        n = 0;
        while (!(imem_req_valid && imem_req_ready && imem_req_addr == addr) && n < 50) begin
            step(1);
            n++;
        end
        checks++;
        if (imem_req_valid && imem_req_ready && imem_req_addr == addr) passes++;
        else $display("FAIL %s: request %h not seen within 50 cycles", name, addr);
    endtask

    task automatic wait_ifid(input string name);
        int n;
        n = 0;
        while (!ifid_valid && n < 50) begin
            step(1);
            n++;
        end
        checks++;
        if (ifid_valid) passes++;
        else $display("FAIL %s: no valid IF/ID within 50 cycles", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pcwrite = 1'b1;
        fdwrite = 1'b1;
        branch_taken = 1'b0;
        branch_target = 32'h0000_0000;
        imem_req_ready = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(1);

        // Reset state while rst is still high
        check32("rst_req_valid", imem_req_valid, 32'd0);
        check32("rst_instr", ifid_instr, NOP);
        check32("rst_pc", ifid_pc, 32'h0000_0000);
        check32("rst_pc4", ifid_pc4, 32'h0000_0004);
        check32("rst_valid", ifid_valid, 32'd0);
        check32("rst_stall", fetch_stall, 32'd0);
        rst = 1'b0;
        #1;
        check32("first_req_valid", imem_req_valid, 32'd1);
        check32("first_req_addr", imem_req_addr, 32'h0000_0000);

        // Zero-wait memory: one instruction every two cycles
        step(1);
        check32("zw_bubble0_valid", ifid_valid, 32'd0);
        check32("zw_bubble0_stall", fetch_stall, 32'd1);
        step(1);
        check32("zw_i0_valid", ifid_valid, 32'd1);
        check32("zw_i0_pc", ifid_pc, 32'h0000_0000);
        check32("zw_i0_instr", ifid_instr, 32'hC0DE_0003);
        check32("zw_i0_stall", fetch_stall, 32'd0);
        step(1);
        check32("zw_bubble1_valid", ifid_valid, 32'd0);
        check32("zw_bubble1_stall", fetch_stall, 32'd1);
        step(1);
        check32("zw_i1_pc", ifid_pc, 32'h0000_0004);
        check32("zw_i1_valid", ifid_valid, 32'd1);

        // Load-use stall for two cycles; response lands in the hold buffer
        pcwrite = 1'b0;
        fdwrite = 1'b0;
        step(1);
        check32("stall_c1_pc", ifid_pc, 32'h0000_0004);
        check32("stall_c1_instr", ifid_instr, 32'hC0DE_0007);
        step(1);
        check32("stall_c2_pc", ifid_pc, 32'h0000_0004);
        check32("hold_no_req", imem_req_valid, 32'd0);
        pcwrite = 1'b1;
        fdwrite = 1'b1;
        step(1);
        check32("hold_out_pc", ifid_pc, 32'h0000_0008);
        check32("hold_out_instr", ifid_instr, 32'hC0DE_000B);
        check32("hold_out_valid", ifid_valid, 32'd1);
        check32("acc_count", acc_q.size(), 32'd3);
        if (acc_q.size() >= 3) begin
            check32("acc0", acc_q[0], 32'h0000_0000);
            check32("acc1", acc_q[1], 32'h0000_0004);
            check32("acc2", acc_q[2], 32'h0000_0008);
        end

        // Branch while the 0x10 request waits for its response
        mem_lat = 3;
        wait_accept("br_wait_acc", 32'h0000_0010);
        step(1);
        branch_taken = 1'b1;
        branch_target = 32'h0000_0100;
        step(1);
        branch_taken = 1'b0;
        mem_lat = 1;
        check32("br_wait_valid", ifid_valid, 32'd0);
        check32("br_wait_instr", ifid_instr, NOP);
        check32("br_wait_drain", imem_req_valid, 32'd0);
        wait_req("br_wait_req");
        check32("br_wait_addr", imem_req_addr, 32'h0000_0100);
        check32("br_wait_discard", ifid_valid, 32'd0);

        // Branch during a stall with the hold buffer full
        pcwrite = 1'b0;
        fdwrite = 1'b0;
        step(2);
        check32("brh_hold_no_req", imem_req_valid, 32'd0);
        pcwrite = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0103;
        step(1);
        branch_taken = 1'b0;
        fdwrite = 1'b1;
        check32("brh_valid", ifid_valid, 32'd0);
        check32("brh_instr", ifid_instr, NOP);
        check32("brh_req_valid", imem_req_valid, 32'd1);
        check32("brh_req_addr", imem_req_addr, 32'h0000_0100);

        // Backpressure: request must hold steady while not accepted
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check32("bp_valid", imem_req_valid, 32'd1);
            check32("bp_addr", imem_req_addr, 32'h0000_0100);
        end
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step(1);
        branch_taken = 1'b0;
        imem_req_ready = 1'b1;
        check32("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_ifid("wrap_ifid");
        check32("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        check32("wrap_pc4", ifid_pc4, 32'h0000_0000);
        check32("wrap_instr", ifid_instr, 32'h3F21_FFFF);
        check32("wrap_next_valid", imem_req_valid, 32'd1);
        check32("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // Reset while a request is outstanding
        wait_accept("rst_wait_acc", 32'h0000_0004);
        mem_lat = 3;
        step(1);
        rst = 1'b1;
        step(1);
        check32("rstw_req_valid", imem_req_valid, 32'd0);
        check32("rstw_instr", ifid_instr, NOP);
        check32("rstw_pc", ifid_pc, 32'h0000_0000);
        check32("rstw_pc4", ifid_pc4, 32'h0000_0004);
        check32("rstw_valid", ifid_valid, 32'd0);
        rst = 1'b0;
        mem_lat = 1;
        #1;
        check32("rstw_drain", imem_req_valid, 32'd0);
        wait_req("rstw_req");
        check32("rstw_addr", imem_req_addr, 32'h0000_0000);
        check32("rstw_discard", ifid_valid, 32'd0);
        step(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
